// File: rtl/aes_dec_pkg.sv
// aes_dec_pkg: block type, FSM states and GF(2^8) helpers
// shared by the AES-128 decrypt sequencer and its core.
package aes_dec_pkg;

  localparam int AES_BLK_W = 128;

  // Byte 0 of a block occupies bits [127:120].
  typedef logic [AES_BLK_W-1:0] aes_blk_t;

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    HOLD
  } state_t;

  function automatic logic [7:0] xt(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gmul(
    input logic [7:0] a,
    input logic [7:0] b
  );
    logic [7:0] p;
    logic [7:0] x;
    p = 8'h00;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = xt(x);
    end
    return p;
  endfunction

  // a^254 is the multiplicative inverse (0 maps to 0).
  function automatic logic [7:0] ginv(input logic [7:0] a);
    logic [7:0] r;
    logic [7:0] b;
    r = 8'h01;
    b = a;
    for (int i = 0; i < 8; i++) begin
      if (i != 0) r = gmul(r, b);
      b = gmul(b, b);
    end
    return r;
  endfunction

  function automatic logic [7:0] sbox(input logic [7:0] x);
    logic [7:0] b;
    b = ginv(x);
    return b ^ {b[6:0], b[7]} ^ {b[5:0], b[7:6]}
             ^ {b[4:0], b[7:5]} ^ {b[3:0], b[7:4]} ^ 8'h63;
  endfunction

  function automatic logic [7:0] isbox(input logic [7:0] y);
    logic [7:0] b;
    b = {y[6:0], y[7]} ^ {y[4:0], y[7:5]}
      ^ {y[1:0], y[7:2]} ^ 8'h05;
    return ginv(b);
  endfunction

endpackage

// File: rtl/main_decry.sv
// main_decry: combinational AES-128 inverse cipher.
// Ports: encr_data (ciphertext), key (cipher key), decr_data (plaintext).
module main_decry
  import aes_dec_pkg::*;
(
  input  aes_blk_t encr_data,
  input  aes_blk_t key,
  output aes_blk_t decr_data
);

  function automatic aes_blk_t key_step(
    input aes_blk_t   k,
    input logic [7:0] rc
  );
    logic [31:0] t;
    aes_blk_t o;
    t = {sbox(k[23:16]) ^ rc, sbox(k[15:8]),
         sbox(k[7:0]), sbox(k[31:24])};
    o[127:96] = k[127:96] ^ t;
    o[95:64]  = k[95:64] ^ o[127:96];
    o[63:32]  = k[63:32] ^ o[95:64];
    o[31:0]   = k[31:0] ^ o[63:32];
    return o;
  endfunction

  // Row r of column c comes from column c-r.
  function automatic aes_blk_t inv_shift(input aes_blk_t s);
    aes_blk_t o;
    o = '0;
    for (int c = 0; c < 4; c++) begin
      for (int r = 0; r < 4; r++) begin
        o[127-8*(4*c+r) -: 8] =
          s[127-8*(4*((c-r+4)%4)+r) -: 8];
      end
    end
    return o;
  endfunction

  function automatic aes_blk_t inv_sub(input aes_blk_t s);
    aes_blk_t o;
    o = '0;
    for (int i = 0; i < 16; i++) begin
      o[127-8*i -: 8] = isbox(s[127-8*i -: 8]);
    end
    return o;
  endfunction

  function automatic aes_blk_t inv_mix(input aes_blk_t s);
    aes_blk_t o;
    logic [7:0] a0, a1, a2, a3;
    o = '0;
    for (int c = 0; c < 4; c++) begin
      a0 = s[127-32*c -: 8];
      a1 = s[119-32*c -: 8];
      a2 = s[111-32*c -: 8];
      a3 = s[103-32*c -: 8];
      o[127-32*c -: 8] = gmul(a0, 8'h0e) ^ gmul(a1, 8'h0b)
                       ^ gmul(a2, 8'h0d) ^ gmul(a3, 8'h09);
      o[119-32*c -: 8] = gmul(a0, 8'h09) ^ gmul(a1, 8'h0e)
                       ^ gmul(a2, 8'h0b) ^ gmul(a3, 8'h0d);
      o[111-32*c -: 8] = gmul(a0, 8'h0d) ^ gmul(a1, 8'h09)
                       ^ gmul(a2, 8'h0e) ^ gmul(a3, 8'h0b);
      o[103-32*c -: 8] = gmul(a0, 8'h0b) ^ gmul(a1, 8'h0d)
                       ^ gmul(a2, 8'h09) ^ gmul(a3, 8'h0e);
    end
    return o;
  endfunction

  function automatic aes_blk_t aes_dec(
    input aes_blk_t ct,
    input aes_blk_t k
  );
    aes_blk_t rk [11];
    aes_blk_t s;
    logic [7:0] rc;
    rk[0] = k;
    rc = 8'h01;
    for (int r = 1; r <= 10; r++) begin
      rk[r] = key_step(rk[r-1], rc);
      rc = xt(rc);
    end
    s = ct ^ rk[10];
    for (int r = 9; r >= 0; r--) begin
      s = inv_sub(inv_shift(s)) ^ rk[r];
      if (r != 0) s = inv_mix(s);
    end
    return s;
  endfunction

  assign decr_data = aes_dec(encr_data, key);

endmodule

// File: rtl/aes_decrypt_ctrl.sv
// aes_decrypt_ctrl: ready/valid sequencer around main_decry with
// key register, SETTLE_CYCLES settle wait and registered output.
// Ports: key_load/key_in/key_ready/key_valid (key), in_valid/
// in_ready/in_data (cipher), out_valid/out_ready/out_data (plain),
// busy; iv_load/iv_in only with macro AES_DEC_CBC_EN (CBC mode).
module aes_decrypt_ctrl
  import aes_dec_pkg::*;
#(
  parameter int SETTLE_CYCLES = 4
) (
  input  logic     clk,
  input  logic     rst_n,
  input  logic     key_load,
  input  aes_blk_t key_in,
  output logic     key_ready,
  output logic     key_valid,
  input  logic     in_valid,
  output logic     in_ready,
  input  aes_blk_t in_data,
  output logic     out_valid,
  input  logic     out_ready,
  output aes_blk_t out_data,
`ifdef AES_DEC_CBC_EN
  input  logic     iv_load,
  input  aes_blk_t iv_in,
`endif
  output logic     busy
);

  localparam int CW = $clog2(SETTLE_CYCLES + 1);
  localparam logic [CW-1:0] CNT_INIT = CW'(SETTLE_CYCLES - 1);

  state_t state_q, state_d;
  aes_blk_t key_reg, cipher_reg, core_out, result;
  logic [CW-1:0] cnt;
  logic hold_off, accept, capture, release_blk;

`ifdef AES_DEC_CBC_EN
  aes_blk_t chain_reg;
  // A same-cycle IV load outranks block intake.
  assign hold_off = key_load | iv_load;
  assign result   = core_out ^ chain_reg;
`else
  assign hold_off = key_load;
  assign result   = core_out;
`endif

  // Core sees only registered operands so it settles undisturbed.
  main_decry u_core (
    .encr_data (cipher_reg),
    .key       (key_reg),
    .decr_data (core_out)
  );

  assign busy = (state_q != IDLE);

  always_comb begin
    state_d     = state_q;
    key_ready   = 1'b0;
    in_ready    = 1'b0;
    accept      = 1'b0;
    capture     = 1'b0;
    release_blk = 1'b0;
    unique case (state_q)
      IDLE: begin
        key_ready = 1'b1;
        in_ready  = key_valid & ~hold_off;
        if (in_valid & key_valid & ~hold_off) begin
          accept  = 1'b1;
          state_d = WAIT;
        end
      end
      WAIT: begin
        if (cnt == '0) begin
          capture = 1'b1;
          state_d = HOLD;
        end
      end
      HOLD: begin
        if (out_ready) begin
          release_blk = 1'b1;
          state_d     = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      key_reg    <= '0;
      key_valid  <= 1'b0;
      cipher_reg <= '0;
      cnt        <= '0;
      out_data   <= '0;
      out_valid  <= 1'b0;
    end else begin
      if (key_ready & key_load) begin
        key_reg   <= key_in;
        key_valid <= 1'b1;
      end
      if (accept) begin
        cipher_reg <= in_data;
        cnt        <= CNT_INIT;
      end else if (state_q == WAIT && cnt != '0) begin
        cnt <= cnt - CW'(1);
      end
      if (capture) begin
        out_data  <= result;
        out_valid <= 1'b1;
      end else if (release_blk) begin
        out_valid <= 1'b0;
      end
    end
  end

`ifdef AES_DEC_CBC_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                  chain_reg <= '0;
    else if (capture)            chain_reg <= cipher_reg;
    else if (key_ready & iv_load) chain_reg <= iv_in;
  end
`endif

endmodule

// File: tb/tb_aes_decrypt_ctrl.sv
// tb_aes_decrypt_ctrl: directed + random checks of aes_decrypt_ctrl
// against an encrypt-side AES model; CBC steps with AES_DEC_CBC_EN.
module tb_aes_decrypt_ctrl;

  localparam int S = 4;

  localparam logic [127:0] FIPS_KEY =
    128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] FIPS_CT =
    128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [127:0] FIPS_PT =
    128'h00112233445566778899aabbccddeeff;

`ifdef AES_DEC_CBC_EN
  localparam bit CBC = 1'b1;
`else
  localparam bit CBC = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic key_load = 1'b0;
  logic in_valid = 1'b0;
  logic out_ready = 1'b0;
  logic [127:0] key_in = '0;
  logic [127:0] in_data = '0;
  logic key_ready, key_valid, in_ready, out_valid, busy;
  logic [127:0] out_data;
`ifdef AES_DEC_CBC_EN
  logic iv_load = 1'b0;
  logic [127:0] iv_in = '0;
`endif

  int n_assert = 0;
  int n_fail = 0;
  logic [127:0] cur_key = '0;
  logic [127:0] chain = '0;
  logic [7:0] sbox_t [256];

  always #5 clk = ~clk;

  aes_decrypt_ctrl #(.SETTLE_CYCLES(S)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .key_load  (key_load),
    .key_in    (key_in),
    .key_ready (key_ready),
    .key_valid (key_valid),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
`ifdef AES_DEC_CBC_EN
    .iv_load   (iv_load),
    .iv_in     (iv_in),
`endif
    .busy      (busy)
  );

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [127:0] obs,
                       input logic [127:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic check1(input string tag, input logic obs,
                        input logic exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic check_i(input string tag, input int obs,
                         input int exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // ---------------- reference model (forward AES) ----------------
  function automatic int rl(input int v, input int n);
    return ((v << n) | (v >> (8 - n))) & 255;
  endfunction

  // S-box from the generator-3 walk over GF(2^8).
  task automatic build_sbox();
    int p, q, x;
    p = 1;
    q = 1;
    do begin
      p = (p ^ (p << 1) ^ (((p & 128) != 0) ? 27 : 0)) & 255;
      q = (q ^ (q << 1)) & 255;
      q = (q ^ (q << 2)) & 255;
      q = (q ^ (q << 4)) & 255;
      if ((q & 128) != 0) q = q ^ 9;
      x = q ^ rl(q, 1) ^ rl(q, 2) ^ rl(q, 3) ^ rl(q, 4);
      sbox_t[p] = 8'((x ^ 99) & 255);
    end while (p != 1);
    sbox_t[0] = 8'h63;
  endtask

  function automatic logic [7:0] x2(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [127:0] aes_enc(input logic [127:0] pt,
                                           input logic [127:0] key);
    logic [7:0] w [176];
    logic [7:0] s [16];
    logic [7:0] t [16];
    logic [7:0] tmp [4];
    logic [7:0] rc, t0, a0, a1, a2, a3;
    logic [127:0] o;
    rc = 8'h01;
    for (int i = 0; i < 16; i++) w[i] = key[127-8*i -: 8];
    for (int i = 16; i < 176; i += 4) begin
      for (int j = 0; j < 4; j++) tmp[j] = w[i-4+j];
      if (i % 16 == 0) begin
        t0 = tmp[0];
        tmp[0] = sbox_t[tmp[1]] ^ rc;
        tmp[1] = sbox_t[tmp[2]];
        tmp[2] = sbox_t[tmp[3]];
        tmp[3] = sbox_t[t0];
        rc = x2(rc);
      end
      for (int j = 0; j < 4; j++) w[i+j] = w[i-16+j] ^ tmp[j];
    end
    for (int i = 0; i < 16; i++) s[i] = pt[127-8*i -: 8] ^ w[i];
    for (int rnd = 1; rnd <= 10; rnd++) begin
      for (int c = 0; c < 4; c++)
        for (int r = 0; r < 4; r++)
          t[4*c+r] = sbox_t[s[4*((c+r)%4)+r]];
      if (rnd < 10) begin
        for (int c = 0; c < 4; c++) begin
          a0 = t[4*c]; a1 = t[4*c+1];
          a2 = t[4*c+2]; a3 = t[4*c+3];
          t[4*c]   = x2(a0) ^ x2(a1) ^ a1 ^ a2 ^ a3;
          t[4*c+1] = a0 ^ x2(a1) ^ x2(a2) ^ a2 ^ a3;
          t[4*c+2] = a0 ^ a1 ^ x2(a2) ^ x2(a3) ^ a3;
          t[4*c+3] = x2(a0) ^ a0 ^ a1 ^ a2 ^ x2(a3);
        end
      end
      for (int i = 0; i < 16; i++) s[i] = t[i] ^ w[16*rnd+i];
    end
    for (int i = 0; i < 16; i++) o[127-8*i -: 8] = s[i];
    return o;
  endfunction

  // Chaining mask applied to the ECB plaintext.
  function automatic logic [127:0] cm(input logic [127:0] c);
    return CBC ? c : 128'h0;
  endfunction

  function automatic logic [127:0] rnd128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  // ---------------- stimulus helpers ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic load_key(input logic [127:0] k);
    key_load = 1'b1;
    key_in = k;
    tick();
    key_load = 1'b0;
    cur_key = k;
    check1("key_valid", key_valid, 1'b1);
  endtask

  // Returns just after the accept edge.
  task automatic send(input logic [127:0] ct);
    in_valid = 1'b1;
    in_data = ct;
    #1;
    for (int i = 0; i < 200 && !in_ready; i++) tick();
    check1("accept_ready", in_ready, 1'b1);
    tick();
    in_valid = 1'b0;
    chain = ct;
  endtask

  // Capture is due S edges after the accept edge.
  task automatic wait_out(input logic [127:0] exp, input string tag,
                          input int n0);
    int n;
    n = n0;
    for (int i = 0; i < 100 && !out_valid; i++) begin
      tick();
      n++;
    end
    check_i({tag, "_lat"}, n, S);
    check({tag, "_data"}, out_data, exp);
  endtask

  task automatic release_out(input int d);
    for (int i = 0; i < d; i++) begin
      tick();
      check1("hold_valid", out_valid, 1'b1);
    end
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    check1("release_valid", out_valid, 1'b0);
    check1("release_busy", busy, 1'b0);
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    logic [127:0] exp, m, ct, k2, k3, ctb, expb;
    int acc [$];
    int per;
    logic hs;

    build_sbox();
    tick();
    tick();
    check1("rst_busy", busy, 1'b0);
    check1("rst_key_valid", key_valid, 1'b0);
    check1("rst_out_valid", out_valid, 1'b0);
    check1("rst_in_ready", in_ready, 1'b0);
    check1("rst_key_ready", key_ready, 1'b1);
    check("rst_out_data", out_data, '0);
    rst_n = 1'b1;

    check("model_fips", aes_enc(FIPS_PT, FIPS_KEY), FIPS_CT);

    // no key yet: block must stall
    in_valid = 1'b1;
    in_data = FIPS_CT;
    for (int i = 0; i < 5; i++) begin
      tick();
      check1("nokey_in_ready", in_ready, 1'b0);
      check1("nokey_out_valid", out_valid, 1'b0);
    end
    key_load = 1'b1;
    key_in = FIPS_KEY;
    #1;
    check1("first_coll_in_ready", in_ready, 1'b0);
    tick();
    key_load = 1'b0;
    cur_key = FIPS_KEY;
    check1("first_key_valid", key_valid, 1'b1);
    exp = FIPS_PT ^ cm(chain);
    send(FIPS_CT);
    wait_out(exp, "fips", 0);
    release_out(0);

    // random traffic
    for (int i = 0; i < 8; i++) begin
      if (i % 3 == 0) load_key(rnd128());
      m = rnd128();
      ct = aes_enc(m, cur_key);
      exp = m ^ cm(chain);
      send(ct);
      wait_out(exp, $sformatf("rand%0d", i), 0);
      release_out(int'($urandom_range(0, 3)));
    end

    // backpressure
    m = rnd128();
    ct = aes_enc(m, cur_key);
    exp = m ^ cm(chain);
    send(ct);
    wait_out(exp, "bp_a", 0);
    m = rnd128();
    ctb = aes_enc(m, cur_key);
    in_valid = 1'b1;
    in_data = ctb;
    for (int i = 0; i < 20; i++) begin
      tick();
      check1("bp_valid", out_valid, 1'b1);
      check("bp_data", out_data, exp);
      check1("bp_in_ready", in_ready, 1'b0);
    end
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    expb = m ^ cm(chain);
    send(ctb);
    wait_out(expb, "bp_b", 0);
    release_out(0);

    // key_load + in_valid in IDLE, then key_load during WAIT
    k2 = rnd128();
    m = rnd128();
    ct = aes_enc(m, k2);
    key_load = 1'b1;
    key_in = k2;
    in_valid = 1'b1;
    in_data = ct;
    #1;
    check1("coll_in_ready", in_ready, 1'b0);
    tick();
    key_load = 1'b0;
    cur_key = k2;
    exp = m ^ cm(chain);
    send(ct);
    tick();
    k3 = rnd128();
    key_load = 1'b1;
    key_in = k3;
    #1;
    check1("wait_key_ready", key_ready, 1'b0);
    tick();
    key_load = 1'b0;
    check1("wait_busy", busy, 1'b1);
    wait_out(exp, "coll", 2);
    release_out(0);
    m = rnd128();
    ct = aes_enc(m, k2);
    exp = m ^ cm(chain);
    send(ct);
    wait_out(exp, "key_kept", 0);
    release_out(0);

    // throughput with out_ready held high
    m = rnd128();
    ct = aes_enc(m, cur_key);
    exp = m ^ cm(chain);
    in_valid = 1'b1;
    in_data = ct;
    out_ready = 1'b1;
    #1;
    for (int e = 1; e <= 20; e++) begin
      hs = in_ready;
      if (hs && acc.size() == 1) check("tp_data", out_data, exp);
      tick();
      if (hs) begin
        acc.push_back(e);
        chain = ct;
      end
    end
    in_valid = 1'b0;
    per = (acc.size() >= 2) ? acc[1] - acc[0] : -1;
    check_i("tp_period", per, S + 2);
    for (int i = 0; i < 100 && busy; i++) tick();
    out_ready = 1'b0;
    check1("tp_drain", busy, 1'b0);

    // asynchronous reset in the middle of WAIT
    m = rnd128();
    ct = aes_enc(m, cur_key);
    send(ct);
    tick();
    rst_n = 1'b0;
    #1;
    check1("mid_rst_out_valid", out_valid, 1'b0);
    check1("mid_rst_key_valid", key_valid, 1'b0);
    check1("mid_rst_busy", busy, 1'b0);
    check("mid_rst_out_data", out_data, '0);
    #1;
    rst_n = 1'b1;
    chain = '0;
    #1;
    check1("post_rst_in_ready", in_ready, 1'b0);
    tick();
    load_key(cur_key);
    m = rnd128();
    ct = aes_enc(m, cur_key);
    exp = m ^ cm(chain);
    send(ct);
    wait_out(exp, "post_rst", 0);
    release_out(1);

`ifdef AES_DEC_CBC_EN
    key_load = 1'b1;
    key_in = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    iv_load = 1'b1;
    iv_in = 128'h000102030405060708090a0b0c0d0e0f;
    in_valid = 1'b1;
    in_data = 128'h7649abac8119b246cee98e9b12e9197d;
    #1;
    check1("cbc_coll_in_ready", in_ready, 1'b0);
    tick();
    key_load = 1'b0;
    iv_load = 1'b0;
    cur_key = key_in;
    chain = iv_in;
    send(128'h7649abac8119b246cee98e9b12e9197d);
    wait_out(128'h6bc1bee22e409f96e93d7e117393172a, "cbc1", 0);
    release_out(0);
    send(128'h5086cb9b507219ee95db113a917678b2);
    wait_out(128'hae2d8a571e03ac9c9eb76fac45af8e51, "cbc2", 0);
    release_out(0);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_assert, n_fail);
    $finish;
  end

endmodule
